sequential_alu: RTL and testbench
=================================

SEQUENTIAL_ALU -- requirements
Module: sequential_alu

Interface
REQ-001 Parameter WIDTH, default 32, is the operand and result width; legal values are 8 to 64.
REQ-002 Parameter OPW, default 5, is the opcode width.
REQ-003 Port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: operation request, sampled on a clock edge.
REQ-006 Port op, input, OPW bits: operation code.
REQ-007 Port a, input, WIDTH bits: operand A.
REQ-008 Port b, input, WIDTH bits: operand B; bits [clog2(WIDTH)-1:0] also give the shift amount.
REQ-009 Port result, output, WIDTH bits: registered result of the last completed operation.
REQ-010 Port busy, output, 1 bit: high while an accepted operation is not yet complete.
REQ-011 Port done, output, 1 bit: one-cycle completion pulse.
REQ-012 Port branch, output, 1 bit: registered branch-taken flag.
REQ-013 Port divzero, output, 1 bit: set on completion of DIV or REM with b==0.

Function
REQ-014 The opcode map SHALL be fixed as follows; all comparisons are unsigned:
- 0 ADD, 1 SUB (two's complement), 2 AND, 3 OR, 4 XOR, 5 NOR, 6 NOT (operates on a)
- 7 SLT, 8 SLE, 9 SGT, 10 SGE, 11 EQ, 12 NEQ
- 13 SRL, 14 SLL
- 15 BEQ, 16 BNE
- 17 MUL (low WIDTH bits), 18 DIV (quotient), 19 REM
REQ-015 A start SHALL be accepted only in state IDLE or DONE; a start in state ITER SHALL be ignored without error.
REQ-016 The state machine SHALL have exactly three states: IDLE, ITER and DONE.
REQ-017 The state transitions SHALL be:
- IDLE or DONE with start and a single-cycle op -> DONE
- IDLE or DONE with start and MUL/DIV/REM -> ITER
- ITER with counter==0 -> DONE
- DONE without start -> IDLE
REQ-018 Single-cycle ops, and DIV/REM with b==0, SHALL update result at the accepting edge, giving done high in the following cycle (latency 1).
REQ-019 MUL, DIV and REM with b!=0 SHALL iterate one bit per cycle, with done high exactly WIDTH+1 cycles after the accepting edge.
REQ-020 MUL SHALL be shift-add and DIV/REM shall be restoring division, with the operands latched at acceptance.
REQ-021 busy SHALL equal (state==ITER); done SHALL equal (state==DONE).
REQ-022 Compare ops SHALL return 1 or 0, zero-extended to WIDTH.
REQ-023 ADD and SUB SHALL wrap modulo 2^WIDTH with no carry output.
REQ-024 Shifts SHALL be logical with zero fill.
REQ-025 BEQ and BNE SHALL update branch only, leaving result unchanged.
REQ-026 branch SHALL hold its value until the next completed BEQ/BNE, or until any completed non-branch op, which clears it to 0.
REQ-027 Division by zero SHALL give DIV result all-ones, REM result = a, and divzero=1.
REQ-028 divzero SHALL be cleared at the completion of any other op.
REQ-029 An undefined opcode SHALL complete with latency 1, result 0 and branch 0.
REQ-030 result SHALL hold its value between completions.
REQ-031 Operand inputs SHALL be don't-care while the block is busy.

Reset
REQ-032 Asserting reset at any time, including mid-ITER, SHALL immediately force state IDLE, clear the iteration counter, and force result=0, busy=0, done=0, branch=0 and divzero=0.
REQ-033 A start coincident with a reset-release edge SHALL NOT be accepted.

Structure
REQ-034 Package alu_pkg SHALL hold the opcode localparams, the state enum (IDLE, ITER, DONE) and a function computing counter width as clog2(WIDTH).
REQ-035 The iterative engine SHALL be a sub-module, alu_muldiv_iter, with ports load/mode/a/b in and finish/lo/hi out.
REQ-036 The remaining operations SHALL be combinational decode in the top level feeding a registered output.

Verification
REQ-037 ADD with a=0xFFFFFFFF, b=1 -> result 0x00000000, done one cycle after acceptance, busy never high.
REQ-038 MUL with a=7, b=6 -> busy for 32 cycles, done 33 cycles after acceptance, result 42; a start issued mid-ITER is ignored.
REQ-039 DIV with a=100, b=7 -> result 14; REM with the same operands -> result 2; DIV with a=5, b=0 -> latency 1, result 0xFFFFFFFF, divzero 1.
REQ-040 BEQ with a=b=9 -> branch 1 and result unchanged; a following ADD -> branch 0.
REQ-041 Reset asserted 10 cycles into a MUL -> all outputs 0 and state IDLE immediately; a new ADD with a=2, b=3 -> result 5 after latency 1.
REQ-042 Back-to-back starts issued in DONE cycles (SLL a=1, b=31, then SRL a=0x80000000, b=31) -> results 0x80000000 then 1, with done high on consecutive cycles.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM state type and sizing helper for the sequential ALU.
// Pure declarations: no latency and no flow control of its own.
package alu_pkg;

  localparam int OP_ADD = 0;
  localparam int OP_SUB = 1;
  localparam int OP_AND = 2;
  localparam int OP_OR  = 3;
  localparam int OP_XOR = 4;
  localparam int OP_NOR = 5;
  localparam int OP_NOT = 6;
  localparam int OP_SLT = 7;
  localparam int OP_SLE = 8;
  localparam int OP_SGT = 9;
  localparam int OP_SGE = 10;
  localparam int OP_EQ  = 11;
  localparam int OP_NEQ = 12;
  localparam int OP_SRL = 13;
  localparam int OP_SLL = 14;
  localparam int OP_BEQ = 15;
  localparam int OP_BNE = 16;
  localparam int OP_MUL = 17;
  localparam int OP_DIV = 18;
  localparam int OP_REM = 19;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bits needed for both the shift amount and the iteration counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider; WIDTH steps after load.
// No backpressure: finish is high in the last step cycle, with lo/hi carrying that step's result.
module alu_muldiv_iter
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             finish,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = cnt_width(WIDTH);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic             active_q, active_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;

  // mode 0: {hi,lo} is the shifting product, y the multiplicand.
  // mode 1: hi is the partial remainder, lo the dividend becoming the quotient, y the divisor.
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    mode_d   = mode_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    y_d      = y_q;
    sum      = {1'b0, hi_q} + {1'b0, (lo_q[0] ? y_q : '0)};
    trial    = {hi_q, lo_q[WIDTH-1]} - {1'b0, y_q};

    if (load) begin
      cnt_d    = CW'(WIDTH - 1);
      active_d = 1'b1;
      mode_d   = mode;
      hi_d     = '0;
      lo_d     = a;
      y_d      = b;
    end else if (active_q) begin
      if (!mode_q) begin
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        hi_d = trial[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
      mode_q   <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      y_q      <= '0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      y_q      <= y_d;
    end
  end

  assign finish = active_q && (cnt_q == '0);
  assign lo     = lo_d;
  assign hi     = hi_d;

endmodule

// File: rtl/sequential_alu.sv
// Multi-function ALU: single-cycle ops and divide-by-zero complete in 1 cycle, MUL/DIV/REM in WIDTH+1.
// No backpressure: start is ignored while busy; done is a one-cycle pulse per completion.
module sequential_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done,
  output logic             branch,
  output logic             divzero
);

  localparam int SHW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             branch_q, branch_d;
  logic             divzero_q, divzero_d;
  logic             rem_sel_q, rem_sel_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             is_br;
  logic             br_taken;
  logic             dz;
  logic             is_mul;
  logic             is_divrem;
  logic             b_zero;
  logic             go_iter;
  logic             eng_load;
  logic             eng_finish;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_hi;

  assign shamt     = b[SHW-1:0];
  assign b_zero    = (b == '0);
  assign is_mul    = (int'(op) == OP_MUL);
  assign is_divrem = (int'(op) == OP_DIV) || (int'(op) == OP_REM);
  assign go_iter   = is_mul || (is_divrem && !b_zero);

  // Single-cycle datapath; DIV/REM entries only matter for the b==0 shortcut.
  always_comb begin
    alu_res  = '0;
    is_br    = 1'b0;
    br_taken = 1'b0;
    dz       = 1'b0;
    case (int'(op))
      OP_ADD: alu_res = a + b;
      OP_SUB: alu_res = a - b;
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_NOT: alu_res = ~a;
      OP_SLT: alu_res[0] = (a < b);
      OP_SLE: alu_res[0] = (a <= b);
      OP_SGT: alu_res[0] = (a > b);
      OP_SGE: alu_res[0] = (a >= b);
      OP_EQ:  alu_res[0] = (a == b);
      OP_NEQ: alu_res[0] = (a != b);
      OP_SRL: alu_res = a >> shamt;
      OP_SLL: alu_res = a << shamt;
      OP_BEQ: begin
        is_br    = 1'b1;
        br_taken = (a == b);
      end
      OP_BNE: begin
        is_br    = 1'b1;
        br_taken = (a != b);
      end
      OP_DIV: begin
        alu_res = '1;
        dz      = 1'b1;
      end
      OP_REM: begin
        alu_res = a;
        dz      = 1'b1;
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    branch_d  = branch_q;
    divzero_d = divzero_q;
    rem_sel_d = rem_sel_q;
    eng_load  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          if (go_iter) begin
            state_d   = ITER;
            eng_load  = 1'b1;
            rem_sel_d = (int'(op) == OP_REM);
          end else begin
            state_d   = DONE;
            divzero_d = dz;
            if (is_br) begin
              branch_d = br_taken;
            end else begin
              branch_d = 1'b0;
              result_d = alu_res;
            end
          end
        end else begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (eng_finish) begin
          state_d   = DONE;
          result_d  = rem_sel_q ? eng_hi : eng_lo;
          branch_d  = 1'b0;
          divzero_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      result_q  <= '0;
      branch_q  <= 1'b0;
      divzero_q <= 1'b0;
      rem_sel_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      branch_q  <= branch_d;
      divzero_q <= divzero_d;
      rem_sel_q <= rem_sel_d;
    end
  end

  alu_muldiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock (clock),
    .reset (reset),
    .load  (eng_load),
    .mode  (is_divrem),
    .a     (a),
    .b     (b),
    .finish(eng_finish),
    .lo    (eng_lo),
    .hi    (eng_hi)
  );

  assign result  = result_q;
  assign busy    = (state_q == ITER);
  assign done    = (state_q == DONE);
  assign branch  = branch_q;
  assign divzero = divzero_q;

endmodule

// File: tb/tb_sequential_alu.sv
// Scoreboarded bench for sequential_alu: directed corner cases then randomized ops vs a reference model.
module tb_sequential_alu;

  localparam int W  = 32;
  localparam int OW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [OW-1:0] op    = '0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic [W-1:0]  result;
  logic          busy, done, branch, divzero;

  sequential_alu #(.WIDTH(W), .OPW(OW)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .result (result),
    .busy   (busy),
    .done   (done),
    .branch (branch),
    .divzero(divzero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic         br;
    logic         dz;
    int           lat;
    int           issue;
  } exp_t;

  exp_t         sbq[$];
  exp_t         mon_e;
  int           errors = 0;
  int           checks = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  int           prev_done_cyc = -10;
  int           last_done_cyc = -10;
  logic [W-1:0] m_res = '0;
  logic         m_br = 1'b0;
  logic         m_dz = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: spec arithmetic on whole operands, one outstanding op at a time.
  task automatic push_exp(input logic [OW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] r;
    int lat;
    r   = '0;
    lat = 1;
    m_dz = 1'b0;
    case (int'(o))
      0:  r = x + y;
      1:  r = x - y;
      2:  r = x & y;
      3:  r = x | y;
      4:  r = x ^ y;
      5:  r = ~(x | y);
      6:  r = ~x;
      7:  r = (x <  y) ? 1 : 0;
      8:  r = (x <= y) ? 1 : 0;
      9:  r = (x >  y) ? 1 : 0;
      10: r = (x >= y) ? 1 : 0;
      11: r = (x == y) ? 1 : 0;
      12: r = (x != y) ? 1 : 0;
      13: r = x >> (y % W);
      14: r = x << (y % W);
      17: begin r = x * y; lat = W + 1; end
      18: if (y == 0) begin r = '1; m_dz = 1'b1; end else begin r = x / y; lat = W + 1; end
      19: if (y == 0) begin r = x;  m_dz = 1'b1; end else begin r = x % y; lat = W + 1; end
      default: r = '0;
    endcase
    if (int'(o) == 15)      m_br = (x == y);
    else if (int'(o) == 16) m_br = (x != y);
    else begin
      m_br  = 1'b0;
      m_res = r;
    end
    e.res   = m_res;
    e.br    = m_br;
    e.dz    = m_dz;
    e.lat   = lat;
    e.issue = cyc;
    sbq.push_back(e);
  endtask

  // Monitor: every done cycle is one completion, popped in issue order.
  always @(negedge clock) begin
    if (reset) begin
      busy_cnt = 0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        prev_done_cyc = last_done_cyc;
        last_done_cyc = cyc;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done high with no op outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = sbq.pop_front();
          chk("result",  result,   mon_e.res);
          chk("branch",  branch,   mon_e.br);
          chk("divzero", divzero,  mon_e.dz);
          chk("latency", cyc - mon_e.issue, mon_e.lat);
          chk("busy_cycles", busy_cnt, mon_e.lat - 1);
        end
        busy_cnt = 0;
      end
    end
  end

  task automatic issue(input logic [OW-1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int guard = 0;
    while (busy && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: busy still 1 after %0d cycles, want 0", guard);
    end
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    push_exp(o, x, y);
    @(negedge clock);
    start = 1'b0;
    op    = OW'($urandom);
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while ((sbq.size() != 0 || busy) && guard < 200) begin
      @(negedge clock);
      guard++;
    end
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d ops outstanding, want 0", sbq.size());
    end
  endtask

  task automatic reset_and_check();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_result",  result,  0);
    chk("rst_busy",    busy,    0);
    chk("rst_done",    done,    0);
    chk("rst_branch",  branch,  0);
    chk("rst_divzero", divzero, 0);
    sbq.delete();
    m_res = '0;
    m_br  = 1'b0;
    m_dz  = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    logic [OW-1:0] ro;
    logic [W-1:0]  ra, rb;
    int            sel;

    repeat (2) @(negedge clock);
    chk("init_result",  result,  0);
    chk("init_busy",    busy,    0);
    chk("init_done",    done,    0);
    chk("init_branch",  branch,  0);
    chk("init_divzero", divzero, 0);
    reset = 1'b0;
    @(negedge clock);

    issue(5'd0, 32'hFFFF_FFFF, 32'd1);
    wait_idle();
    chk("add_wrap", result, 0);

    issue(5'd17, 32'd7, 32'd6);
    repeat (5) @(negedge clock);
    start = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
    @(negedge clock);
    start = 1'b0;
    wait_idle();
    chk("mul_42", result, 42);

    issue(5'd18, 32'd100, 32'd7);
    issue(5'd19, 32'd100, 32'd7);
    issue(5'd18, 32'd5,   32'd0);
    wait_idle();
    chk("div0_result", result, 32'hFFFF_FFFF);
    chk("div0_flag",   divzero, 1);

    issue(5'd15, 32'd9, 32'd9);
    wait_idle();
    chk("beq_taken", branch, 1);
    chk("beq_keeps_result", result, 32'hFFFF_FFFF);
    issue(5'd0, 32'd1, 32'd2);
    wait_idle();
    chk("add_clears_branch", branch, 0);

    issue(5'd15, 32'd4, 32'd4);
    issue(5'd17, 32'd123, 32'd456);
    repeat (9) @(negedge clock);
    reset_and_check();
    issue(5'd0, 32'd2, 32'd3);
    wait_idle();
    chk("add_after_reset", result, 5);

    issue(5'd14, 32'd1, 32'd31);
    issue(5'd13, 32'h8000_0000, 32'd31);
    wait_idle();
    chk("srl_result", result, 1);
    chk("b2b_done_gap", last_done_cyc - prev_done_cyc, 1);

    for (int i = 0; i < 80; i++) begin
      ro  = OW'($urandom_range(0, 23));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = '0;
        1:       rb = ra;
        2:       rb = $urandom_range(1, 40);
        3:       begin ra = $urandom_range(0, 1000); rb = $urandom_range(0, 1000); end
        default: rb = $urandom;
      endcase
      issue(ro, ra, rb);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end
    wait_idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
